// File: rtl/generate_sequence_using_fsm.sv
// Serial pattern transmitter: shifts PATTERN out MSB first, repeats it with an
// idle gap between copies, and pulses done after the final bit.
module generate_sequence_using_fsm #(
  parameter int               WIDTH      = 6,
  parameter logic [WIDTH-1:0] PATTERN    = 6'b110011,
  parameter int               GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] repeat_cnt,
  input  logic       abort,
  output logic       a,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int              IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] BIT_LAST = IDXW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] bit_idx_q, bit_idx_d;
  logic [3:0]      copy_q, copy_d;
  logic [3:0]      total_q, total_d;
  logic [3:0]      gap_q, gap_d;
  logic [3:0]      copy_inc;

  // Pattern reordered so that bit_idx addresses it directly in transmit order.
  logic [WIDTH-1:0] pat_msb_first;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pat
    assign pat_msb_first[gi] = PATTERN[WIDTH-1-gi];
  end

  assign copy_inc = copy_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_idx_q <= '0;
      copy_q    <= '0;
      total_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      copy_q    <= copy_d;
      total_q   <= total_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    copy_d    = copy_q;
    total_d   = total_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d   = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
          bit_idx_d = '0;
          copy_d    = '0;
          gap_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // Abort outranks every advance condition below.
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_idx_q == BIT_LAST) begin
          copy_d    = copy_inc;
          bit_idx_d = '0;
          gap_d     = '0;
          if (copy_inc < total_q) begin
            state_d = (GAP_CYCLES == 0) ? S_SEND : S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          bit_idx_d = '0;
          state_d   = S_SEND;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    a     = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_SEND: begin
        a     = pat_msb_first[bit_idx_q];
        valid = 1'b1;
        busy  = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_generate_sequence_using_fsm.sv
// Bench for generate_sequence_using_fsm: two instances (gap 2 and gap 0) share
// stimulus and are compared every cycle against an arithmetic stream model.
module tb_generate_sequence_using_fsm;

  localparam int         W   = 6;
  localparam logic [5:0] PAT = 6'b110011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] repeat_cnt;
  logic       a1, v1, b1, d1;
  logic       a2, v2, b2, d2;

  int total = 0;
  int bad   = 0;

  int         hits[$];
  logic [5:0] sr2;
  int         bitpos2;

  always #5 clk = ~clk;

  generate_sequence_using_fsm #(.WIDTH(6), .PATTERN(6'b110011), .GAP_CYCLES(2)) dut_gap2 (
    .clk(clk), .rst_n(rst_n), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
    .a(a1), .valid(v1), .busy(b1), .done(d1)
  );

  generate_sequence_using_fsm #(.WIDTH(6), .PATTERN(6'b110011), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
    .a(a2), .valid(v2), .busy(b2), .done(d2)
  );

  function automatic int busy_len(input int n, input int gap);
    int ne;
    ne = (n == 0) ? 1 : n;
    return ne * W + (ne - 1) * gap;
  endfunction

  // Expected {a,valid,busy,done} in cycle i after the accepted start edge.
  function automatic logic [3:0] exp_at(input int n, input int gap, input int i);
    int bl;
    int pos;
    logic [5:0] p;
    p  = PAT;
    bl = busy_len(n, gap);
    if (i < bl) begin
      pos = i % (W + gap);
      if (pos < W) return {p[W-1-pos], 1'b1, 1'b1, 1'b0};
      return 4'b0010;
    end
    if (i == bl) return 4'b0001;
    return 4'b0000;
  endfunction

  // mode 0: plain; 1: start held through SEND/DONE (ends on DONE);
  // 2: abort after cycle ev_idx; 3: abort asserted during DONE.
  task automatic run_tx(input int n, input int mode, input int ev_idx, input string tag);
    int         len;
    int         bl;
    logic [3:0] e1, e2, o1, o2;
    logic       aborted;
    int         nbad0;
    nbad0   = bad;
    aborted = 1'b0;
    sr2     = '0;
    bitpos2 = 0;
    bl      = busy_len(n, 2);
    len     = (mode == 1) ? bl + 1 : bl + 3;
    start      = 1'b1;
    repeat_cnt = 4'(n);
    @(posedge clk);
    #1;
    start      = 1'b0;
    repeat_cnt = 4'($urandom_range(0, 15));
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e1 = aborted ? 4'b0000 : exp_at(n, 2, i);
      e2 = aborted ? 4'b0000 : exp_at(n, 0, i);
      o1 = {a1, v1, b1, d1};
      o2 = {a2, v2, b2, d2};
      total++;
      if (o1 !== e1) begin
        bad++;
        $display("FAIL %s gap2 cycle=%0d got a/v/b/d=%b want=%b", tag, i, o1, e1);
      end
      total++;
      if (o2 !== e2) begin
        bad++;
        $display("FAIL %s gap0 cycle=%0d got a/v/b/d=%b want=%b", tag, i, o2, e2);
      end
      if (v2 === 1'b1) begin
        sr2 = {sr2[4:0], a2};
        bitpos2++;
        if (bitpos2 >= W && sr2 == PAT) hits.push_back(bitpos2);
      end
      start = (mode == 1 && i <= bl);
      if ((mode == 2 && i == ev_idx) || (mode == 3 && i == bl)) abort = 1'b1;
      if (mode == 2 && i == ev_idx) aborted = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
    end
    $display("tx %s n=%0d mode=%0d cycles=%0d errors=%0d", tag, n, mode, len, bad - nbad0);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    repeat_cnt = 4'd0;
    #12;
    total++;
    if ({a1, v1, b1, d1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset gap2 got=%b want=0000", {a1, v1, b1, d1});
    end
    total++;
    if ({a2, v2, b2, d2} !== 4'b0000) begin
      bad++;
      $display("FAIL reset gap0 got=%b want=0000", {a2, v2, b2, d2});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("tx reset errors=%0d", bad);
  endtask

  task automatic test_single();
    run_tx(1, 0, 0, "single_n1");
    run_tx(0, 0, 0, "single_n0");
  endtask

  task automatic test_repeat();
    run_tx(3, 0, 0, "repeat_n3");
  endtask

  task automatic test_gap0_detector();
    hits.delete();
    run_tx(2, 0, 0, "detect_n2");
    total++;
    if (hits.size() != 2 || hits[0] != 6 || hits[1] != 12) begin
      bad++;
      $display("FAIL detector hits=%0d first=%0d last=%0d want 2 hits at 6,12",
               hits.size(), (hits.size() > 0) ? hits[0] : -1,
               (hits.size() > 0) ? hits[hits.size()-1] : -1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_tx($urandom_range(0, 15), 0, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_tx(1, 1, 0, "restart_ignored");
    run_tx(1, 0, 0, "start_after_done");
  endtask

  task automatic test_abort();
    run_tx($urandom_range(1, 15), 2, 2, "abort_bit3");
    run_tx(3, 2, 7, "abort_gap");
    run_tx(1, 3, 0, "abort_in_done");
  endtask

  task automatic test_async_reset();
    start      = 1'b1;
    repeat_cnt = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) @(posedge clk);
    @(negedge clk);
    total++;
    if ({a1, v1, b1, d1} !== 4'b0010) begin
      bad++;
      $display("FAIL pre_reset_gap gap2 got=%b want=0010", {a1, v1, b1, d1});
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a1, v1, b1, d1} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset gap2 got=%b want=0000", {a1, v1, b1, d1});
    end
    total++;
    if ({a2, v2, b2, d2} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset gap0 got=%b want=0000", {a2, v2, b2, d2});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({a1, v1, b1, d1, a2, v2, b2, d2} !== 8'h00) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=00000000", {a1, v1, b1, d1, a2, v2, b2, d2});
    end
    $display("tx async_reset errors=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat();
    test_gap0_detector();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
